// File: rtl/music_player.sv
// music_player
//   Beat sequencer and square-wave synthesiser for an external tone table.
//   The beat index advances at a selectable tempo. Playback can be started,
//   stopped or paused, and can either loop or play once. The current tone in
//   Hz is turned into a 1-bit audio signal by a phase-continuous accumulator.
//
// Ports
//   i_clk       system clock
//   i_rst       synchronous active-high reset
//   i_start     pulse: restart playback from beat 0
//   i_stop      pulse: abort to idle (wins over i_start)
//   i_pause     level: hold playback while high
//   i_loopEn    1 = wrap to beat 0 at song end, 0 = play once
//   i_tempoSel  beat period = BEAT_TICKS >> i_tempoSel
//   o_beatNum   registered index into the tone table
//   i_toneIn    tone for o_beatNum from the table (combinational, same cycle)
//   o_toneOut   registered active tone in Hz
//   o_audio     square wave at o_toneOut Hz
//   o_busy      high while playing or paused
//   o_done      one-cycle pulse when a one-shot song finishes
module music_player #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BEAT_W     = 9,
    parameter int SONG_LEN   = 260,
    parameter int BEAT_TICKS = 12_500_000,
    parameter int TONE_W     = 32,
    parameter int SILENCE_HZ = 20000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_stop,
    input  logic              i_pause,
    input  logic              i_loopEn,
    input  logic [1:0]        i_tempoSel,
    output logic [BEAT_W-1:0] o_beatNum,
    input  logic [TONE_W-1:0] i_toneIn,
    output logic [TONE_W-1:0] o_toneOut,
    output logic              o_audio,
    output logic              o_busy,
    output logic              o_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PLAY,
        ST_PAUSE
    } state_t;

    localparam logic [31:0]       BEAT_TICKS_V = 32'(BEAT_TICKS);
    localparam logic [31:0]       HALF_HZ      = 32'(CLK_HZ / 2);
    localparam logic [BEAT_W-1:0] LAST_BEAT    = BEAT_W'(SONG_LEN - 1);
    localparam logic [TONE_W-1:0] SILENCE      = TONE_W'(SILENCE_HZ);

    state_t              r_state;
    state_t              w_stateNext;
    logic [31:0]         r_tickCnt;
    logic [31:0]         r_acc;
    logic [BEAT_W-1:0]   r_beatNum;
    logic [TONE_W-1:0]   r_toneOut;
    logic                r_audio;
    logic                r_busy;
    logic                r_done;

    logic [31:0]         w_period;
    logic                w_endBeat;
    logic                w_lastBeat;
    logic                w_silent;
    logic [32:0]         w_sum;
    logic [31:0]         w_accWrap;
    logic                w_clear;
    logic                w_run;
    logic                w_doneNext;

    // Tempo can change mid-beat, so the end-of-beat test is ">=": a shorter
    // period selected after the counter has already passed it ends the beat
    // on the very next playing cycle instead of running on.
    // The period is assumed to be at least 1 for every tempo selection.
    assign w_period   = BEAT_TICKS_V >> i_tempoSel;
    assign w_endBeat  = (r_tickCnt >= (w_period - 32'd1));
    assign w_lastBeat = (r_beatNum == LAST_BEAT);

    // A zero tone or anything at/above the silence threshold means "rest".
    // The accumulator adds the tone every cycle and subtracts half the clock
    // rate on overflow, so the output toggles 2*tone times per second on
    // average and keeps its phase across tone changes.
    assign w_silent  = (r_toneOut == '0) || (r_toneOut >= SILENCE);
    assign w_sum     = {1'b0, r_acc} + 33'(r_toneOut);
    assign w_accWrap = 32'(w_sum - {1'b0, HALF_HZ});

    // State register; busy is registered alongside so it matches the state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_stateNext;
            r_busy  <= (w_stateNext != ST_IDLE);
            r_done  <= w_doneNext;
        end
    end

    // Next-state logic with stop > start > pause priority. w_clear zeroes
    // the counters and accumulator, w_run marks a cycle of active playback.
    always_comb begin
        w_stateNext = r_state;
        w_clear     = 1'b0;
        w_run       = 1'b0;
        w_doneNext  = 1'b0;
        if (i_stop) begin
            w_stateNext = ST_IDLE;
            w_clear     = 1'b1;
        end else if (i_start) begin
            w_stateNext = ST_PLAY;
            w_clear     = 1'b1;
        end else begin
            case (r_state)
                ST_PLAY: begin
                    if (i_pause) begin
                        w_stateNext = ST_PAUSE;
                    end else begin
                        w_run = 1'b1;
                        if (w_endBeat && w_lastBeat && !i_loopEn) begin
                            w_stateNext = ST_IDLE;
                            w_clear     = 1'b1;
                            w_doneNext  = 1'b1;
                            w_run       = 1'b0;
                        end
                    end
                end
                ST_PAUSE: begin
                    if (!i_pause) begin
                        w_stateNext = ST_PLAY;
                    end
                end
                default: begin
                    w_stateNext = r_state;
                end
            endcase
        end
    end

    // Beat/tick counters, tone register and accumulator. Outside active
    // playback the counters hold (so a pause resumes mid-beat) while the
    // tone is forced to silence and the audio line is held low.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_tickCnt <= '0;
            r_beatNum <= '0;
            r_acc     <= '0;
            r_toneOut <= SILENCE;
            r_audio   <= 1'b0;
        end else if (w_clear) begin
            r_tickCnt <= '0;
            r_beatNum <= '0;
            r_acc     <= '0;
            r_toneOut <= SILENCE;
            r_audio   <= 1'b0;
        end else if (w_run) begin
            r_toneOut <= i_toneIn;
            if (w_endBeat) begin
                r_tickCnt <= '0;
                r_beatNum <= w_lastBeat ? '0 : r_beatNum + 1'b1;
            end else begin
                r_tickCnt <= r_tickCnt + 32'd1;
            end
            if (w_silent) begin
                r_acc   <= '0;
                r_audio <= 1'b0;
            end else if (w_sum >= {1'b0, HALF_HZ}) begin
                r_acc   <= w_accWrap;
                r_audio <= ~r_audio;
            end else begin
                r_acc <= w_sum[31:0];
            end
        end else begin
            r_toneOut <= SILENCE;
            r_audio   <= 1'b0;
        end
    end

    assign o_beatNum = r_beatNum;
    assign o_toneOut = r_toneOut;
    assign o_audio   = r_audio;
    assign o_busy    = r_busy;
    assign o_done    = r_done;

endmodule
